npu_layer_sequencer: RTL and testbench
======================================

// Module: npu_layer_sequencer
// PURPOSE
//  Control sequencer between the image/conv/dense RAM bank set and npu_top. On start it streams N_CFG weight
//  words into the NPU config path, then n_step feature words with weights, then collects N_OUT result bytes
//  from D_OUT. It tracks the argmax and raises ready with the winning class.
// PARAMETERS
//  IMG_AW   10    image RAM address width (4 byte banks, read as one 32-bit word)
//  W_AW     15    dense RAM address width (4 byte banks, read as one 32-bit word)
//  N_CFG    16    config words sent with en_config before feeding
//  N_OUT    10    result bytes expected on d_out
//  TIMEOUT  4096  DRAIN cycles with no d_out_valid before abandoning
// PORTS
//  clk          in   1       system clock
//  reset        in   1       synchronous, active-high reset
//  start        in   1       1-cycle start pulse; ignored unless in IDLE or DONE
//  abort        in   1       return to IDLE from any state
//  n_step       in   IMG_AW  feature words to feed; sampled on accepted start
//  img_addr     out  IMG_AW  image RAM read address (port b)
//  w_addr       out  W_AW    dense RAM read address (port b)
//  img_rd       in   32      {bank3,bank2,bank1,bank0}; valid 1 cycle after img_addr
//  w_rd         in   32      {bank3..bank0}; valid 1 cycle after w_addr
//  d_bus        out  64      {DH,DG,DF,DE,DD,DC,DB,DA}; DA = [7:0]
//  en_config    out  1       d_bus holds a config word this cycle
//  en_fsm       out  1       d_bus holds a feed word this cycle
//  d_out        in   8       NPU result byte
//  d_out_valid  in   1       d_out strobe
//  busy         out  1       state is CFG, FEED or DRAIN
//  ready        out  1       result valid (DONE)
//  err          out  1       DRAIN timed out; valid while ready
//  answer       out  4       argmax index over received results
//  max_val      out  8       winning value (unsigned)
// BEHAVIOUR
//  Reset (and abort): state=IDLE. All outputs 0. Counters, argmax and pipe-valid cleared.
//  States: IDLE -> CFG -> FEED -> DRAIN -> DONE. A start in DONE restarts at CFG and clears ready, err and argmax.
//  CFG: cycle k issues w_addr=k for k=0..N_CFG-1. Go to FEED after k=N_CFG-1, or to DRAIN if n_step==0.
//  FEED: cycle s issues img_addr=s and w_addr=N_CFG+s for s=0..n_step-1. Go to DRAIN after s=n_step-1.
//  Read pipe: 1-cycle registered valid/kind stage. The cycle after an issue, d_bus and en_* are registered outputs:
//   config: d_bus={w_rd,32'h0}, en_config=1.
//   feed:   d_bus={w_rd,img_rd}, en_fsm=1.
//  The pipe drains across state changes: the last config word appears in FEED cycle 0.
//  en_config and en_fsm are never high together. d_bus=0 whenever both are low.
//  Results: d_out_valid is counted in FEED and DRAIN only, while rcnt<N_OUT. Strobes are dropped elsewhere and after N_OUT.
//  Argmax: update on d_out > max_val (strictly greater), so the lowest index wins ties. Index = rcnt at capture.
//  The first result always loads (max_val init 0, index 0).
//  DRAIN -> DONE when rcnt==N_OUT, including the cycle of the final strobe.
//  Timeout: a DRAIN idle counter resets on each strobe. At TIMEOUT-1 the block goes to DONE with err=1; answer/max_val keep partial values.
//  DONE: ready=1, busy=0. answer/max_val held until restart or reset.
//  Simultaneous events: reset > abort > start. abort while in the DONE state also clears ready.
//  Address widths: counters are W_AW wide, and N_CFG+n_step must fit W_AW (not checked).
// STRUCTURE
//  Package npu_seq_pkg: state_t enum {IDLE,CFG,FEED,DRAIN,DONE}, DBUS_W=64, lane-index constants, pipe kind enum.
//  Sub-module argmax_tracker: clear, valid, din[7:0], idx -> max_val, answer. The FSM, counters and read pipe stay in the top.
// TESTING
//  1. N_CFG=16, n_step=4, start -> en_config exactly 16 cycles, w_addr 0..15, then en_fsm 4 cycles, w_addr 16..19, img_addr 0..3.
//  2. w_rd=addr pattern -> d_bus[63:32] equals the w_addr issued the previous cycle; en_config/en_fsm never overlap, no gap or duplicate.
//  3. results 3,9,9,1,0,0,0,0,0,0 -> ready=1, answer=1, max_val=9, err=0; 11th strobe ignored.
//  4. n_step=0 -> CFG goes straight to DRAIN, en_fsm never asserts; 10 strobes -> DONE.
//  5. only 5 strobes then silence -> err=1, ready=1 after TIMEOUT idle cycles; answer = argmax of the 5.
//  6. abort mid-FEED, then reset mid-CFG -> next cycle IDLE, all outputs 0; start then repeats test 1 exactly.

Source files
------------

// File: rtl/npu_seq_pkg.sv
// Shared types and bus layout for the NPU layer sequencer.
package npu_seq_pkg;

  localparam int DBUS_W = 64;
  localparam int WORD_W = 32;
  localparam int LANE_W = 8;
  localparam int ANS_W  = 4;

  localparam int LANE_DA = 0;
  localparam int LANE_DB = 1;
  localparam int LANE_DC = 2;
  localparam int LANE_DD = 3;
  localparam int LANE_DE = 4;
  localparam int LANE_DF = 5;
  localparam int LANE_DG = 6;
  localparam int LANE_DH = 7;

  // Feature word occupies DA..DD, weight word occupies DE..DH.
  localparam int LO_WORD_LSB = LANE_DA * LANE_W;
  localparam int HI_WORD_LSB = LANE_DE * LANE_W;

  typedef enum logic [2:0] {
    IDLE,
    CFG,
    FEED,
    DRAIN,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    PK_NONE,
    PK_CFG,
    PK_FEED
  } pipe_kind_t;

endpackage

// File: rtl/npu_layer_sequencer_argmax.sv
// Running argmax over NPU result bytes; strictly-greater update keeps the lowest index on ties.
module argmax_tracker
  import npu_seq_pkg::*;
#(
  parameter int VAL_W = 8,
  parameter int IDX_W = ANS_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             valid,
  input  logic [VAL_W-1:0] din,
  input  logic [IDX_W-1:0] idx,
  output logic [VAL_W-1:0] max_val,
  output logic [IDX_W-1:0] answer
);

  logic [VAL_W-1:0] max_val_q, max_val_d;
  logic [IDX_W-1:0] answer_q, answer_d;

  always_comb begin
    max_val_d = max_val_q;
    answer_d  = answer_q;
    if (clear) begin
      max_val_d = '0;
      answer_d  = '0;
    end else if (valid && (din > max_val_q)) begin
      max_val_d = din;
      answer_d  = idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      max_val_q <= '0;
      answer_q  <= '0;
    end else begin
      max_val_q <= max_val_d;
      answer_q  <= answer_d;
    end
  end

  assign max_val = max_val_q;
  assign answer  = answer_q;

endmodule

// File: rtl/npu_layer_sequencer.sv
// Streams config and feature/weight words from the RAM banks into npu_top, then collects
// the result bytes and reports the winning class.
module npu_layer_sequencer
  import npu_seq_pkg::*;
#(
  parameter int IMG_AW  = 10,
  parameter int W_AW    = 15,
  parameter int N_CFG   = 16,
  parameter int N_OUT   = 10,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [IMG_AW-1:0] n_step,
  output logic [IMG_AW-1:0] img_addr,
  output logic [W_AW-1:0]   w_addr,
  input  logic [31:0]       img_rd,
  input  logic [31:0]       w_rd,
  output logic [DBUS_W-1:0] d_bus,
  output logic              en_config,
  output logic              en_fsm,
  input  logic [7:0]        d_out,
  input  logic              d_out_valid,
  output logic              busy,
  output logic              ready,
  output logic              err,
  output logic [ANS_W-1:0]  answer,
  output logic [7:0]        max_val
);

  localparam int RC_W = $clog2(N_OUT + 1);
  localparam int ID_W = $clog2(TIMEOUT);

  localparam logic [W_AW-1:0] CFG_LAST = W_AW'(N_CFG - 1);
  localparam logic [W_AW-1:0] CFG_BASE = W_AW'(N_CFG);
  localparam logic [RC_W-1:0] RC_FULL  = RC_W'(N_OUT);
  localparam logic [RC_W-1:0] RC_LAST  = RC_W'(N_OUT - 1);
  localparam logic [ID_W-1:0] TO_LAST  = ID_W'(TIMEOUT - 1);

  state_t          state_q, state_d;
  pipe_kind_t      pipe_q, pipe_d;
  logic [W_AW-1:0] cnt_q, cnt_d;
  logic [W_AW-1:0] n_step_q, n_step_d;
  logic [RC_W-1:0] rcnt_q, rcnt_d;
  logic [ID_W-1:0] idle_q, idle_d;
  logic            err_q, err_d;
  logic            res_take;
  logic            arg_clear;

  assign res_take = !abort && d_out_valid && (state_q inside {FEED, DRAIN})
                    && (rcnt_q < RC_FULL);

  always_comb begin
    state_d   = state_q;
    pipe_d    = PK_NONE;
    cnt_d     = cnt_q;
    n_step_d  = n_step_q;
    rcnt_d    = rcnt_q;
    idle_d    = idle_q;
    err_d     = err_q;
    arg_clear = 1'b0;

    if (res_take) begin
      rcnt_d = rcnt_q + 1'b1;
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = CFG;
          cnt_d     = '0;
          n_step_d  = W_AW'(n_step);
          rcnt_d    = '0;
          idle_d    = '0;
          err_d     = 1'b0;
          arg_clear = 1'b1;
        end
      end
      CFG: begin
        pipe_d = PK_CFG;
        if (cnt_q == CFG_LAST) begin
          cnt_d   = '0;
          state_d = (n_step_q == '0) ? DRAIN : FEED;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FEED: begin
        pipe_d = PK_FEED;
        if (cnt_q == n_step_q - W_AW'(1)) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        // The final accepted strobe completes the layer in the same cycle.
        if ((rcnt_q == RC_FULL) || (res_take && (rcnt_q == RC_LAST))) begin
          state_d = DONE;
        end else if (d_out_valid) begin
          idle_d = '0;
        end else if (idle_q == TO_LAST) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d   = IDLE;
      pipe_d    = PK_NONE;
      cnt_d     = '0;
      rcnt_d    = '0;
      idle_d    = '0;
      err_d     = 1'b0;
      arg_clear = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pipe_q   <= PK_NONE;
      cnt_q    <= '0;
      n_step_q <= '0;
      rcnt_q   <= '0;
      idle_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pipe_q   <= pipe_d;
      cnt_q    <= cnt_d;
      n_step_q <= n_step_d;
      rcnt_q   <= rcnt_d;
      idle_q   <= idle_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    img_addr = '0;
    w_addr   = '0;
    case (state_q)
      CFG:  w_addr = cnt_q;
      FEED: begin
        img_addr = cnt_q[IMG_AW-1:0];
        w_addr   = CFG_BASE + cnt_q;
      end
      default: ;
    endcase
  end

  // RAM data arrives one cycle after the address, aligned with the registered pipe kind.
  always_comb begin
    d_bus = '0;
    case (pipe_q)
      PK_CFG:  d_bus[HI_WORD_LSB +: WORD_W] = w_rd;
      PK_FEED: begin
        d_bus[HI_WORD_LSB +: WORD_W] = w_rd;
        d_bus[LO_WORD_LSB +: WORD_W] = img_rd;
      end
      default: ;
    endcase
  end

  assign en_config = (pipe_q == PK_CFG);
  assign en_fsm    = (pipe_q == PK_FEED);
  assign busy      = state_q inside {CFG, FEED, DRAIN};
  assign ready     = (state_q == DONE);
  assign err       = err_q;

  argmax_tracker #(
    .VAL_W(8),
    .IDX_W(ANS_W)
  ) u_argmax (
    .clk    (clk),
    .reset  (reset),
    .clear  (arg_clear),
    .valid  (res_take),
    .din    (d_out),
    .idx    (ANS_W'(rcnt_q)),
    .max_val(max_val),
    .answer (answer)
  );

endmodule

// File: tb/tb_npu_layer_sequencer.sv
// Directed and randomized checks of npu_layer_sequencer against a cycle-indexed reference model.
module tb_npu_layer_sequencer;

  localparam int NCFG = 16;
  localparam int NOUT = 10;
  localparam int TMO  = 4096;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [9:0]  n_step = '0;
  logic [9:0]  img_addr;
  logic [14:0] w_addr;
  logic [31:0] img_rd = '0;
  logic [31:0] w_rd = '0;
  logic [63:0] d_bus;
  logic        en_config, en_fsm;
  logic [7:0]  d_out = '0;
  logic        d_out_valid = 1'b0;
  logic        busy, ready, err;
  logic [3:0]  answer;
  logic [7:0]  max_val;

  logic [31:0] salt_w = '0;
  logic [31:0] salt_i = '0;
  logic [7:0]  res [0:15];
  int          n_pass = 0;
  int          n_total = 0;
  int          n_fail = 0;

  npu_layer_sequencer #(
    .IMG_AW (10),
    .W_AW   (15),
    .N_CFG  (NCFG),
    .N_OUT  (NOUT),
    .TIMEOUT(TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .n_step     (n_step),
    .img_addr   (img_addr),
    .w_addr     (w_addr),
    .img_rd     (img_rd),
    .w_rd       (w_rd),
    .d_bus      (d_bus),
    .en_config  (en_config),
    .en_fsm     (en_fsm),
    .d_out      (d_out),
    .d_out_valid(d_out_valid),
    .busy       (busy),
    .ready      (ready),
    .err        (err),
    .answer     (answer),
    .max_val    (max_val)
  );

  always #5 clk = ~clk;

  // Synchronous RAM stubs: word content is the address scrambled by a per-run salt.
  always @(posedge clk) begin
    w_rd   <= {17'b0, w_addr} ^ salt_w;
    img_rd <= {22'b0, img_addr} ^ salt_i;
  end

  function automatic logic [31:0] wword(input int a);
    return 32'(a) ^ salt_w;
  endfunction

  function automatic logic [31:0] iword(input int a);
    return 32'(a) ^ salt_i;
  endfunction

  function automatic logic [105:0] pk(input logic [14:0] w, input logic [9:0] i,
                                      input logic ec, input logic ef, input logic b,
                                      input logic r, input logic e, input logic [3:0] a,
                                      input logic [7:0] m, input logic [63:0] d);
    return {w, i, ec, ef, b, r, e, a, m, d};
  endfunction

  function automatic logic [105:0] observed();
    return pk(w_addr, img_addr, en_config, en_fsm, busy, ready, err, answer, max_val, d_bus);
  endfunction

  // Lowest index holding the largest value among the first k results.
  function automatic void ref_argmax(input int k, output logic [3:0] a, output logic [7:0] m);
    int best_i = 0;
    int best_v = 0;
    for (int i = 0; i < k; i++) begin
      if (int'(res[i]) > best_v) begin
        best_v = int'(res[i]);
        best_i = i;
      end
    end
    a = 4'(best_i);
    m = 8'(best_v);
  endfunction

  task automatic chk(input string tag, input logic [105:0] obs, input logic [105:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_zero(input string tag);
    chk(tag, observed(), pk('0, '0, 0, 0, 0, 0, 0, '0, '0, '0));
  endtask

  task automatic check_done(input string tag, input int k, input logic e);
    logic [3:0] a;
    logic [7:0] m;
    ref_argmax(k, a, m);
    chk(tag, observed(), pk('0, '0, 0, 0, 0, 1, e, a, m, '0));
  endtask

  task automatic pulse_start(input int n);
    n_step = 10'(n);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Cycle c counts from 1 = first cycle after the start edge.
  task automatic check_window(input int n, input bit stray);
    for (int c = 1; c <= n + NCFG + 2; c++) begin
      int          ew, ei;
      logic        ec, ef;
      logic [63:0] eb;
      ew = (c <= NCFG + n) ? c - 1 : 0;
      ei = (c > NCFG && c <= NCFG + n) ? c - NCFG - 1 : 0;
      ec = (c >= 2 && c <= NCFG + 1);
      ef = (c >= NCFG + 2 && c <= NCFG + 1 + n);
      eb = ec ? {wword(c - 2), 32'h0} : ef ? {wword(c - 2), iword(c - NCFG - 2)} : 64'h0;
      chk($sformatf("win n=%0d c=%0d", n, c), observed(),
          pk(15'(ew), 10'(ei), ec, ef, 1'b1, 1'b0, 1'b0, '0, '0, eb));
      d_out       = 8'hFF;
      d_out_valid = stray && (c <= NCFG - 1) && ($urandom_range(0, 2) == 0);
      @(negedge clk);
    end
    d_out_valid = 1'b0;
  endtask

  task automatic send_results(input int k, input int maxgap);
    for (int i = 0; i < k; i++) begin
      d_out       = res[i];
      d_out_valid = 1'b1;
      @(negedge clk);
      d_out_valid = 1'b0;
      if (i < k - 1) repeat ($urandom_range(0, maxgap)) @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] pa;
    logic [7:0] pm;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check_zero("idle");

    // n_step=4 with addr-pattern RAM, then the directed result set.
    salt_w = '0;
    salt_i = '0;
    pulse_start(4);
    check_window(4, 1'b0);
    res[0] = 8'd3; res[1] = 8'd9; res[2] = 8'd9; res[3] = 8'd1;
    for (int i = 4; i < NOUT; i++) res[i] = 8'd0;
    send_results(NOUT, 0);
    check_done("directed_done", NOUT, 1'b0);
    d_out       = 8'd200;
    d_out_valid = 1'b1;
    @(negedge clk);
    d_out_valid = 1'b0;
    check_done("eleventh_ignored", NOUT, 1'b0);

    // Restart from DONE with n_step=0.
    salt_w = $urandom;
    pulse_start(0);
    check_window(0, 1'b1);
    for (int i = 0; i < NOUT; i++) res[i] = 8'($urandom_range(0, 20));
    send_results(NOUT, 2);
    check_done("nstep0_done", NOUT, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_zero("abort_in_done");

    // Randomized layers with stray strobes during config.
    for (int r = 0; r < 4; r++) begin
      int n;
      n      = int'($urandom_range(1, 8));
      salt_w = $urandom;
      salt_i = $urandom;
      pulse_start(n);
      check_window(n, 1'b1);
      for (int i = 0; i < NOUT; i++) res[i] = 8'($urandom_range(0, 20));
      send_results(NOUT, 3);
      check_done($sformatf("rand_done r=%0d", r), NOUT, 1'b0);
    end

    // Partial results then silence: timeout.
    salt_w = $urandom;
    salt_i = $urandom;
    pulse_start(2);
    check_window(2, 1'b0);
    for (int i = 0; i < 5; i++) res[i] = 8'($urandom_range(0, 255));
    send_results(5, 0);
    ref_argmax(5, pa, pm);
    repeat (TMO - 1) @(negedge clk);
    chk("timeout_edge", observed(), pk('0, '0, 0, 0, 1, 0, 0, pa, pm, '0));
    @(negedge clk);
    check_done("timeout_done", 5, 1'b1);

    // Abort mid-FEED, reset mid-CFG, then repeat the first layer exactly.
    pulse_start(6);
    repeat (18) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_zero("abort_feed");
    pulse_start(6);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_zero("reset_cfg");
    salt_w = '0;
    salt_i = '0;
    pulse_start(4);
    check_window(4, 1'b0);
    res[0] = 8'd3; res[1] = 8'd9; res[2] = 8'd9; res[3] = 8'd1;
    for (int i = 4; i < NOUT; i++) res[i] = 8'd0;
    send_results(NOUT, 0);
    check_done("repeat_done", NOUT, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
